// File: rtl/data_memory_sized.sv
// Word-array data memory for the MEM stage: byte/half/word loads and stores with
// sign/zero extension, a valid/ready request port and a fixed registered read latency.
module data_memory_sized #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic              resp_valid,
    output logic [31:0]       read_data,
    output logic              resp_err
);

    localparam int unsigned     IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT  = (ADDR_W+1)'(DEPTH * 4);
    localparam logic [1:0]      LAT_M1 = 2'(READ_LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [31:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] load_q, load_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] read_data_q, read_data_d;

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [31:0]      word;
    logic             misaligned, out_of_range, illegal, req_err;
    logic             accept, wr_en;
    logic [3:0]       wmask;
    logic [31:0]      wdata;
    logic [7:0]       b_sel;
    logic [15:0]      h_sel;
    logic [31:0]      load_ext;

    assign idx  = address[IDX_W+1:2];
    assign lane = address[1:0];
    assign word = mem[idx];

    always_comb begin
        misaligned   = (size == 2'b01 && address[0]) || (size == 2'b10 && address[1:0] != 2'b00);
        out_of_range = {1'b0, address} >= LIMIT;
        illegal      = (size == 2'b11) || (MemRead && MemWrite);
        req_err      = misaligned || out_of_range || illegal;
    end

    // A request with neither MemRead nor MemWrite is not work and is never accepted.
    assign req_ready = (state_q == IDLE);
    assign accept    = rst_n && req_valid && req_ready && (MemRead || MemWrite);
    assign wr_en     = accept && MemWrite && !req_err;

    always_comb begin
        wmask = 4'b1111;
        wdata = write_data;
        case (size)
            2'b00: begin
                wmask = 4'b0001 << lane;
                wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                wmask = address[1] ? 4'b1100 : 4'b0011;
                wdata = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        b_sel    = word[{lane, 3'b000} +: 8];
        h_sel    = address[1] ? word[31:16] : word[15:0];
        load_ext = '0;
        case (size)
            2'b00:   load_ext = is_unsigned ? {24'h0, b_sel} : {{24{b_sel[7]}}, b_sel};
            2'b01:   load_ext = is_unsigned ? {16'h0, h_sel} : {{16{h_sel[15]}}, h_sel};
            2'b10:   load_ext = word;
            default: load_ext = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            load_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            load_q       <= load_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            read_data_q  <= read_data_d;
        end
    end

    // The load value is captured at accept; the output register only carries it in the response cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        load_d       = load_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        read_data_d  = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = LAT_M1;
                    err_d   = req_err;
                    load_d  = (req_err || MemWrite) ? '0 : load_ext;
                end
            end
            BUSY: begin
                if (cnt_q == 2'd0) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_q;
                    read_data_d  = load_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign read_data  = read_data_q;

endmodule
